// File: rtl/jtkcpu_cenbus.sv
// Clock-enable generator for the KCPU: fractional-rate cen/cen2 from clk,
// with ROM wait-state stretching and optional re-issue of stalled ticks.
module jtkcpu_cenbus #(
  parameter int NUM      = 1,
  parameter int DEN      = 4,
  parameter int CW       = 5,
  parameter int RECW     = 4,
  parameter int RECOVERY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rom_cs,
  input  logic            rom_ok,
  output logic            cen,
  output logic            cen2,
  output logic            stall,
  output logic [RECW-1:0] owed
);

  localparam logic [CW:0]     NUM_W    = (CW+1)'(NUM);
  localparam logic [CW:0]     DEN_W    = (CW+1)'(DEN);
  localparam bit              REC_EN   = (RECOVERY != 0);
  localparam logic [RECW-1:0] OWED_MAX = '1;
  localparam logic [RECW-1:0] OWED_ONE = RECW'(1);

  logic [CW-1:0] acc;
  logic [CW-1:0] acc_nxt;
  logic [CW:0]   sum;
  logic [CW:0]   diff;
  logic          ph;
  logic          nat;
  logic          inj;
  logic          cand;
  logic          hold;
  logic          issue;

  // rom_cs/rom_ok act as a request/valid pair: while rom_cs is high and
  // rom_ok is low the ROM has no data, so any cen-phase tick is held back.
  always_comb begin
    sum     = {1'b0, acc} + NUM_W;
    diff    = sum - DEN_W;
    nat     = (sum >= DEN_W);
    acc_nxt = nat ? diff[CW-1:0] : sum[CW-1:0];
    // Injection only fills gaps: never on a natural edge, never right after an enable
    inj     = REC_EN && (owed != '0) && !nat && !cen2;
    cand    = nat || inj;
    hold    = cand && ph && rom_cs && !rom_ok;
    issue   = cand && !hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      ph    <= 1'b0;
      cen   <= 1'b0;
      cen2  <= 1'b0;
      stall <= 1'b0;
      owed  <= '0;
    end else begin
      acc  <= acc_nxt;
      cen2 <= issue;
      cen  <= issue && ph;
      if (issue) ph <= ~ph;
      if (hold) stall <= 1'b1;
      else if (issue && ph) stall <= 1'b0;
      // Only lost natural ticks are owed; a held injection simply retries later
      if (hold && nat) begin
        if (REC_EN && owed != OWED_MAX) owed <= owed + OWED_ONE;
      end else if (issue && inj) begin
        owed <= owed - OWED_ONE;
      end
    end
  end

endmodule

// File: tb/tb_jtkcpu_cenbus.sv
// Bench for jtkcpu_cenbus: four parameterisations driven in lockstep, checked
// per cycle against a tick-count model and per phase against a vector table.
module tb_jtkcpu_cenbus;

  logic clk = 1'b0;
  logic rst, rom_cs, rom_ok;
  logic cen_a, cen2_a, stall_a; logic [3:0] owed_a;
  logic cen_b, cen2_b, stall_b; logic [3:0] owed_b;
  logic cen_c, cen2_c, stall_c; logic [1:0] owed_c;
  logic cen_d, cen2_d, stall_d; logic [3:0] owed_d;

  always #5 clk = ~clk;

  jtkcpu_cenbus #(.NUM(1), .DEN(4), .CW(5), .RECW(4), .RECOVERY(1)) u_a (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_ok(rom_ok),
    .cen(cen_a), .cen2(cen2_a), .stall(stall_a), .owed(owed_a));
  jtkcpu_cenbus #(.NUM(3), .DEN(8), .CW(5), .RECW(4), .RECOVERY(1)) u_b (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_ok(rom_ok),
    .cen(cen_b), .cen2(cen2_b), .stall(stall_b), .owed(owed_b));
  jtkcpu_cenbus #(.NUM(1), .DEN(4), .CW(5), .RECW(2), .RECOVERY(1)) u_c (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_ok(rom_ok),
    .cen(cen_c), .cen2(cen2_c), .stall(stall_c), .owed(owed_c));
  jtkcpu_cenbus #(.NUM(1), .DEN(4), .CW(5), .RECW(4), .RECOVERY(0)) u_d (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_ok(rom_ok),
    .cen(cen_d), .cen2(cen2_d), .stall(stall_d), .owed(owed_d));

  // Model: natural ticks come from the edge count n (tick when floor(n*NUM/DEN)
  // advances); phase is the parity of the number of ticks issued so far.
  typedef struct {
    int num; int den; int recmax; bit rec;
    int n; int issued; int owed; bit stall; bit cen; bit cen2;
  } mdl_t;

  typedef struct {
    bit r; bit cs; bit ok; int cycles;
    int owed_a; int stall_a; int owed_c; int owed_d;
    int cen2_a; int cen2_c; int cen_a; int cen2_b; int cen_b; bit adj;
  } vec_t;

  mdl_t ma, mb, mc, md;
  vec_t tbl[9];
  int tests = 0;
  int fails = 0;
  int n2a, n2b, n2c, n1a, n1b, adj_err;
  bit pa, pb, pc, pd;

  function automatic mdl_t mk(input int num, input int den, input int recw, input bit rec);
    mdl_t m;
    m.num = num; m.den = den; m.recmax = (1 << recw) - 1; m.rec = rec;
    m.n = 0; m.issued = 0; m.owed = 0; m.stall = 0; m.cen = 0; m.cen2 = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit r, input bit cs, input bit ok);
    mdl_t x;
    bit nat, inj, cand, supp, iss, ph;
    x = m;
    if (r) begin
      x.n = 0; x.issued = 0; x.owed = 0; x.stall = 0; x.cen = 0; x.cen2 = 0;
      return x;
    end
    x.n  = m.n + 1;
    nat  = ((x.n * m.num) / m.den) != (((x.n - 1) * m.num) / m.den);
    inj  = m.rec && (m.owed > 0) && !nat && !m.cen2;
    cand = nat || inj;
    ph   = (m.issued % 2) == 1;
    supp = cand && ph && cs && !ok;
    iss  = cand && !supp;
    x.cen2 = iss;
    x.cen  = iss && ph;
    if (iss) x.issued = m.issued + 1;
    if (supp) x.stall = 1'b1;
    else if (iss && ph) x.stall = 1'b0;
    if (supp && nat) begin
      if (m.rec && m.owed < m.recmax) x.owed = m.owed + 1;
    end else if (iss && inj) begin
      x.owed = m.owed - 1;
    end
    return x;
  endfunction

  function automatic int pk(input logic c, input logic c2, input logic s, input int o);
    return (c ? 10000 : 0) + (c2 ? 1000 : 0) + (s ? 100 : 0) + o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit cs, input bit ok, input bit adj);
    rst = r; rom_cs = cs; rom_ok = ok;
    @(posedge clk);
    ma = mstep(ma, r, cs, ok);
    mb = mstep(mb, r, cs, ok);
    mc = mstep(mc, r, cs, ok);
    md = mstep(md, r, cs, ok);
    @(negedge clk);
    check("a cen/cen2/stall/owed", pk(cen_a, cen2_a, stall_a, int'(owed_a)), pk(ma.cen, ma.cen2, ma.stall, ma.owed));
    check("b cen/cen2/stall/owed", pk(cen_b, cen2_b, stall_b, int'(owed_b)), pk(mb.cen, mb.cen2, mb.stall, mb.owed));
    check("c cen/cen2/stall/owed", pk(cen_c, cen2_c, stall_c, int'(owed_c)), pk(mc.cen, mc.cen2, mc.stall, mc.owed));
    check("d cen/cen2/stall/owed", pk(cen_d, cen2_d, stall_d, int'(owed_d)), pk(md.cen, md.cen2, md.stall, md.owed));
    n2a += int'(cen2_a); n2b += int'(cen2_b); n2c += int'(cen2_c);
    n1a += int'(cen_a);  n1b += int'(cen_b);
    if (adj && ((pa && cen2_a) || (pb && cen2_b) || (pc && cen2_c) || (pd && cen2_d))) adj_err++;
    if (adj && ((cen_a && !cen2_a) || (cen_b && !cen2_b))) adj_err++;
    pa = cen2_a; pb = cen2_b; pc = cen2_c; pd = cen2_d;
  endtask

  initial begin
    rst = 1'b1; rom_cs = 1'b0; rom_ok = 1'b0;
    ma = mk(1, 4, 4, 1'b1);
    mb = mk(3, 8, 4, 1'b1);
    mc = mk(1, 4, 2, 1'b1);
    md = mk(1, 4, 4, 1'b0);
    //         r  cs ok cyc oa sa oc od c2a c2c c1a c2b c1b adj
    tbl[0] = '{1, 0, 0,  2, 0, 0, 0, 0,  0,  0,  0,  0,  0, 0};
    tbl[1] = '{0, 0, 0, 64, 0, 0, 0, 0, 16, 16,  8, 24, 12, 1};
    tbl[2] = '{0, 1, 0, 16, 3, 1, 3, 0,  1,  1,  0, -1, -1, 0};
    tbl[3] = '{0, 1, 1, 48, 0, 0, 0, 0, 15, 15,  8, -1, -1, 0};
    tbl[4] = '{0, 1, 0, 28, 6, 1, 3, 0,  1,  1,  0, -1, -1, 0};
    tbl[5] = '{0, 1, 1, 36, 0, 0, 0, 0, 15, 12, -1, -1, -1, 0};
    tbl[6] = '{0, 1, 0, 12, 2, 1, 3, 0,  1,  0,  0, -1, -1, 0};
    tbl[7] = '{1, 1, 0,  1, 0, 0, 0, 0,  0,  0,  0,  0,  0, 0};
    tbl[8] = '{0, 0, 0,  4, 0, 0, 0, 0,  1,  1,  0, -1, -1, 0};

    for (int i = 0; i < 9; i++) begin
      n2a = 0; n2b = 0; n2c = 0; n1a = 0; n1b = 0; adj_err = 0;
      pa = 0; pb = 0; pc = 0; pd = 0;
      for (int k = 0; k < tbl[i].cycles; k++) step(tbl[i].r, tbl[i].cs, tbl[i].ok, tbl[i].adj);
      check($sformatf("row%0d owed_a", i), int'(owed_a), tbl[i].owed_a);
      check($sformatf("row%0d stall_a", i), int'(stall_a), tbl[i].stall_a);
      check($sformatf("row%0d owed_c", i), int'(owed_c), tbl[i].owed_c);
      check($sformatf("row%0d owed_d", i), int'(owed_d), tbl[i].owed_d);
      check($sformatf("row%0d cen2 count a", i), n2a, tbl[i].cen2_a);
      check($sformatf("row%0d cen2 count c", i), n2c, tbl[i].cen2_c);
      if (tbl[i].cen_a >= 0) check($sformatf("row%0d cen count a", i), n1a, tbl[i].cen_a);
      if (tbl[i].cen2_b >= 0) check($sformatf("row%0d cen2 count b", i), n2b, tbl[i].cen2_b);
      if (tbl[i].cen_b >= 0) check($sformatf("row%0d cen count b", i), n1b, tbl[i].cen_b);
      if (tbl[i].adj) check($sformatf("row%0d adjacent enables", i), adj_err, 0);
      if (tbl[i].r) check($sformatf("row%0d reset outputs", i),
                          int'({cen_a, cen2_a, cen_b, cen2_b, stall_b, owed_b, cen_c, cen2_c, stall_c}), 0);
    end

    // First cen2 after reset release lands exactly on edge 4
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("post-reset edge %0d cen2_a", k), int'(cen2_a), (k == 4) ? 1 : 0);
    end

    // Random ROM handshake traffic with occasional resets, model-checked per cycle
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
